// File: rtl/uart_tx_fifo_unit.sv
// uart_tx_fifo_unit: buffered 8N1 UART transmitter.
// Byte stores push into a circular FIFO; a serializer drains it onto uart_tx
// at CLKS_PER_BIT clocks per bit, chaining frames back-to-back when data waits.
//
// state | meaning
// IDLE  | line high, waiting for FIFO data
// START | start bit (low) for one bit period
// DATA  | eight data bits, LSB first
// STOP  | stop bit (high); pops next byte at its end if one is queued
module uart_tx_fifo_unit #(
  parameter int CLKS_PER_BIT = 87,
  parameter int DEPTH_LOG2   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [7:0]            wr_data,
  input  logic                  clr_overflow,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  overflow,
  output logic                  tx_busy,
  output logic                  uart_tx
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int TW    = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0]         T_LAST   = TW'(CLKS_PER_BIT - 1);
  localparam logic [DEPTH_LOG2:0]   CNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                 state_q, state_d;
  logic [TW-1:0]          timer_q, timer_d;
  logic [2:0]             idx_q, idx_d;
  logic [7:0]             shift_q, shift_d;
  logic                   tx_q, tx_d;

  logic [7:0]             mem [DEPTH];
  logic [DEPTH_LOG2-1:0]  wr_ptr, rd_ptr;
  logic [DEPTH_LOG2:0]    count;
  logic                   push, pop, bit_end;

  assign full    = (count == CNT_FULL);
  assign empty   = (count == '0);
  assign level   = count;
  assign tx_busy = (state_q != IDLE) || !empty;
  assign uart_tx = tx_q;

  // full is the pre-edge value, so a write while full is dropped even if a pop coincides
  assign push    = wr_en && !full;
  assign bit_end = (timer_q == T_LAST);

  // FIFO storage write port; contents need no reset since count gates reads
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // FIFO pointers, occupancy count and sticky overflow flag
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // set wins over a same-cycle clear
      if (wr_en && full)     overflow <= 1'b1;
      else if (clr_overflow) overflow <= 1'b0;
    end
  end

  // serializer next-state, pop request and next line value
  always_comb begin
    state_d = state_q;
    timer_d = bit_end ? '0 : timer_q + 1'b1;
    idx_d   = idx_q;
    shift_d = shift_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (!empty) begin
          pop     = 1'b1;
          shift_d = mem[rd_ptr];
          state_d = START;
        end
      end
      START: begin
        idx_d = 3'd0;
        if (bit_end) state_d = DATA;
      end
      DATA: begin
        if (bit_end) begin
          shift_d = {1'b0, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (!empty) begin
            pop     = 1'b1;
            shift_d = mem[rd_ptr];
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // line value derives from the next state so the register output is glitch-free
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  // serializer state register; reset abandons any partial frame
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      timer_q <= '0;
      idx_q   <= 3'd0;
      shift_q <= 8'd0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

endmodule
